// File: rtl/muldiv_issue_ctrl_if.sv
// muldiv_issue_ctrl_if: decode request, HI/LO read and MulDiv handshake bundle
interface muldiv_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_ready;
    logic             rd_hi;
    logic             rd_lo;
    logic [WIDTH-1:0] rd_data;
    logic             stall;
    logic             busy;
    logic             md_start;
    logic             md_signed;
    logic             md_div;
    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             err_timeout;

    // issue controller side
    modport slave (
        input  req_valid, req_op, req_a, req_b, rd_hi, rd_lo, md_done, md_hi, md_lo,
        output req_ready, rd_data, stall, busy, md_start, md_signed, md_div, md_a, md_b,
               hi, lo, err_timeout
    );

    // decode / MulDiv environment side
    modport master (
        output req_valid, req_op, req_a, req_b, rd_hi, rd_lo, md_done, md_hi, md_lo,
        input  req_ready, rd_data, stall, busy, md_start, md_signed, md_div, md_a, md_b,
               hi, lo, err_timeout
    );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: issues mul/div ops to the MulDiv unit and owns architectural HI/LO
module muldiv_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    muldiv_issue_ctrl_if.slave bus
);
    localparam int         CW      = $clog2(TIMEOUT);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] WAIT    = 1'b1;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_start;
    logic             r_signed;
    logic             r_div;
    logic             r_err;

    logic w_idle;
    logic w_wait;
    logic w_issue;
    logic w_mthi;
    logic w_mtlo;
    logic w_done;
    logic w_tmo;

    assign w_idle  = r_state == IDLE;
    assign w_wait  = r_state == WAIT;
    // ops 000-011 go to MulDiv, except a divide by zero which is silently dropped
    assign w_issue = w_idle && bus.req_valid && !bus.req_op[2] && !(bus.req_op[1] && bus.req_b == '0);
    assign w_mthi  = w_idle && bus.req_valid && bus.req_op == OP_MTHI;
    assign w_mtlo  = w_idle && bus.req_valid && bus.req_op == OP_MTLO;
    // a done overlapping the start pulse belongs to no op of ours
    assign w_done  = w_wait && bus.md_done && !r_start;
    assign w_tmo   = w_wait && !w_done && r_cnt == CW'(TIMEOUT - 1);

    // IDLE/WAIT state and the WAIT cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (w_issue) begin
            r_state <= WAIT;
            r_cnt   <= '0;
        end else if (w_done || w_tmo) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (w_wait) begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // operand/mode latch held for the whole WAIT, plus the one-cycle start pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_div    <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            r_start <= w_issue;
            if (w_issue) begin
                r_a      <= bus.req_a;
                r_b      <= bus.req_b;
                r_signed <= !bus.req_op[0];
                r_div    <= bus.req_op[1];
            end
        end
    end

    // architectural HI/LO: written by MTHI/MTLO in IDLE or by the MulDiv result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            r_hi <= bus.md_hi;
            r_lo <= bus.md_lo;
        end else begin
            if (w_mthi) r_hi <= bus.req_a;
            if (w_mtlo) r_lo <= bus.req_a;
        end
    end

    // sticky flag recording that an op was abandoned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_err <= 1'b0;
        else if (w_tmo) r_err <= 1'b1;
    end

    assign bus.req_ready   = w_idle;
    assign bus.busy        = w_wait;
    assign bus.stall       = (bus.rd_hi || bus.rd_lo) && w_wait;
    assign bus.rd_data     = bus.rd_hi ? r_hi : r_lo;
    assign bus.md_start    = r_start;
    assign bus.md_signed   = r_signed;
    assign bus.md_div      = r_div;
    assign bus.md_a        = r_a;
    assign bus.md_b        = r_b;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.err_timeout = r_err;
endmodule
